// File: rtl/pool_seq_pkg.sv
// Shared types for the max-pooling window sequencer: FSM encoding, default
// widths and the latched configuration bundle.
package pool_seq_pkg;

   localparam int ADDR_W_DEF = 16;
   localparam int DIM_W_DEF  = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GEN   = 2'd1,
      FLUSH = 2'd2
   } state_t;

   typedef struct packed {
      logic [ADDR_W_DEF-1:0] in_base;
      logic [ADDR_W_DEF-1:0] out_base;
      logic [DIM_W_DEF-1:0]  in_w;
      logic [DIM_W_DEF-1:0]  kw_m1;
      logic [DIM_W_DEF-1:0]  kh_m1;
      logic [DIM_W_DEF-1:0]  stride_m1;
      logic [DIM_W_DEF-1:0]  ow_m1;
      logic [DIM_W_DEF-1:0]  oh_m1;
   } cfg_t;

endpackage

// File: rtl/pool_wrap_counter.sv
// One loop axis: counts 0..term while enabled; wrap pulses on the count that
// returns to zero so the next-outer axis can be chained from it.
module pool_wrap_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] term,
   output logic [W-1:0] cnt,
   output logic         wrap
);

   assign wrap = en && (cnt == term);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= (cnt == term) ? '0 : cnt + W'(1);
      end
   end

endmodule

// File: rtl/pool_window_sequencer.sv
// Address/control sequencer for a max-pooling datapath: walks every kernel
// window of a row-major image, emitting read addresses, first/last strobes.
//
//   state | meaning
//   IDLE  | finished or never started; done=1
//   GEN   | issuing one element per advance (running & ready)
//   FLUSH | final registered outputs retire; then back to IDLE
module pool_window_sequencer
   import pool_seq_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DIM_W  = DIM_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              run,
   input  logic              running,
   input  logic              ready,
   input  logic [ADDR_W-1:0] in_base,
   input  logic [ADDR_W-1:0] out_base,
   input  logic [DIM_W-1:0]  in_w,
   input  logic [DIM_W-1:0]  kw_m1,
   input  logic [DIM_W-1:0]  kh_m1,
   input  logic [DIM_W-1:0]  stride_m1,
   input  logic [DIM_W-1:0]  ow_m1,
   input  logic [DIM_W-1:0]  oh_m1,
   output logic [ADDR_W-1:0] addr,
   output logic              addr_valid,
   output logic              first,
   output logic              last,
   output logic [ADDR_W-1:0] out_addr,
   output logic              done
);

   state_t state_q, state_d;
   cfg_t   cfg_q;

   logic [ADDR_W-1:0] srow_q;
   logic [ADDR_W-1:0] row_base_q;
   logic [ADDR_W-1:0] row_ptr_q;
   logic [ADDR_W-1:0] col_ptr_q;
   logic [ADDR_W-1:0] out_ptr_q;

   logic [DIM_W-1:0] kx, ky, ox, oy;
   logic             wrap_kx, wrap_ky, wrap_ox, wrap_oy;
   logic             adv;

   logic [DIM_W:0]     s_in;
   logic [2*DIM_W:0]   srow_in;
   logic [ADDR_W-1:0]  s_step;
   logic [ADDR_W-1:0]  cur_addr;
   logic               is_first, is_last;

   // Row stride in elements is formed once when config is latched; the
   // per-element path below only ever adds.
   assign s_in     = {1'b0, stride_m1} + (DIM_W+1)'(1);
   assign srow_in  = (2*DIM_W+1)'(s_in) * (2*DIM_W+1)'(in_w);
   assign s_step   = ADDR_W'(cfg_q.stride_m1) + ADDR_W'(1);
   assign cur_addr = row_ptr_q + col_ptr_q + ADDR_W'(kx);
   assign is_first = (kx == '0) && (ky == '0);
   assign is_last  = (kx == cfg_q.kw_m1) && (ky == cfg_q.kh_m1);
   assign done     = (state_q == IDLE);

   pool_wrap_counter #(.W(DIM_W)) u_kx (
      .clk(clk), .rst(rst), .clr(run), .en(adv),
      .term(cfg_q.kw_m1), .cnt(kx), .wrap(wrap_kx)
   );
   pool_wrap_counter #(.W(DIM_W)) u_ky (
      .clk(clk), .rst(rst), .clr(run), .en(wrap_kx),
      .term(cfg_q.kh_m1), .cnt(ky), .wrap(wrap_ky)
   );
   pool_wrap_counter #(.W(DIM_W)) u_ox (
      .clk(clk), .rst(rst), .clr(run), .en(wrap_ky),
      .term(cfg_q.ow_m1), .cnt(ox), .wrap(wrap_ox)
   );
   pool_wrap_counter #(.W(DIM_W)) u_oy (
      .clk(clk), .rst(rst), .clr(run), .en(wrap_ox),
      .term(cfg_q.oh_m1), .cnt(oy), .wrap(wrap_oy)
   );

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // run restarts from any state and takes priority over an advance.
   always_comb begin
      state_d = state_q;
      adv     = 1'b0;
      if (run) begin
         state_d = GEN;
      end else if (running) begin
         case (state_q)
            GEN: begin
               adv = ready;
               if (ready && wrap_oy) state_d = FLUSH;
            end
            FLUSH:   state_d = IDLE;
            default: state_d = state_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cfg_q      <= '0;
         srow_q     <= '0;
         row_base_q <= '0;
         row_ptr_q  <= '0;
         col_ptr_q  <= '0;
         out_ptr_q  <= '0;
         addr       <= '0;
         addr_valid <= 1'b0;
         first      <= 1'b0;
         last       <= 1'b0;
         out_addr   <= '0;
      end else begin
         addr_valid <= adv;
         if (run) begin
            cfg_q      <= '{in_base, out_base, in_w, kw_m1, kh_m1,
                            stride_m1, ow_m1, oh_m1};
            srow_q     <= ADDR_W'(srow_in);
            row_base_q <= in_base;
            row_ptr_q  <= in_base;
            col_ptr_q  <= '0;
            out_ptr_q  <= out_base;
            first      <= 1'b0;
            last       <= 1'b0;
         end else if (adv) begin
            addr     <= cur_addr;
            first    <= is_first;
            last     <= is_last;
            out_addr <= out_ptr_q;
            if (wrap_oy) begin
               // Rewind so the idle pointers match the latched config.
               row_base_q <= cfg_q.in_base;
               row_ptr_q  <= cfg_q.in_base;
               col_ptr_q  <= '0;
               out_ptr_q  <= cfg_q.out_base;
            end else begin
               if (wrap_ox) begin
                  row_base_q <= row_base_q + srow_q;
                  row_ptr_q  <= row_base_q + srow_q;
                  col_ptr_q  <= '0;
               end else if (wrap_ky) begin
                  row_ptr_q <= row_base_q;
                  col_ptr_q <= col_ptr_q + s_step;
               end else if (wrap_kx) begin
                  row_ptr_q <= row_ptr_q + ADDR_W'(cfg_q.in_w);
               end
               if (wrap_ky) out_ptr_q <= out_ptr_q + ADDR_W'(1);
            end
         end
      end
   end

endmodule
